// File: rtl/dpram_pkg.sv
// ============================================================================
// dpram_pkg : shared types and constants for the byte-enable dual-port RAM
// Revision  : 1.0
// ============================================================================
`default_nettype none

package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dpram_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

`default_nettype wire

// File: rtl/dpram_port_pipe.sv
// ============================================================================
// dpram_port_pipe : per-port read-data/valid pipeline, 1 or 2 cycles deep
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dpram_port_pipe #(
  parameter int DATA_W  = 256,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] q,
  output logic              qv
);

  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;

  // Data registers only load on a valid beat so q holds between pulses.
  always_comb begin
    s1_vld_d  = in_vld;
    s1_data_d = in_vld ? in_data : s1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              s2_vld_q, s2_vld_d;
      logic [DATA_W-1:0] s2_data_q, s2_data_d;

      always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld_q  <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q  <= s2_vld_d;
          s2_data_q <= s2_data_d;
        end
      end

      assign q  = s2_data_q;
      assign qv = s2_vld_q;
    end else begin : g_no_out_reg
      assign q  = s1_data_q;
      assign qv = s1_vld_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/dpram_be_clr.sv
// ============================================================================
// dpram_be_clr : true dual-port RAM with byte enables, post-reset clear and
//                same-address write-collision flag
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dpram_be_clr
  import dpram_pkg::*;
#(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 5,
  parameter int OUT_REG    = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  input  logic                 en_a,
  input  logic                 wen_a,
  input  logic [DATA_W/8-1:0]  be_a,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [DATA_W-1:0]    d_a,
  output logic [DATA_W-1:0]    q_a,
  output logic                 qv_a,
  input  logic                 en_b,
  input  logic                 wen_b,
  input  logic [DATA_W/8-1:0]  be_b,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic [DATA_W-1:0]    d_b,
  output logic [DATA_W-1:0]    q_b,
  output logic                 qv_b,
  output logic                 collision
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  dpram_state_t      state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;
  logic              collision_q, collision_d;

  logic              acc_a, acc_b, wr_a, wr_b, same_addr, clr_we;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, rdata_a, rdata_b;

  assign acc_a     = init_done_q & en_a;
  assign acc_b     = init_done_q & en_b;
  assign wr_a      = acc_a & wen_a;
  assign wr_b      = acc_b & wen_b;
  assign same_addr = (addr_a == addr_b);
  assign clr_we    = (state_q == ST_CLEAR);
  assign old_a     = mem[addr_a];
  assign old_b     = mem[addr_b];

  // Post-write image of each addressed entry; A owns bytes both ports enable.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BE_W; i++) begin
      if (wr_a && be_a[i])
        new_a[i*8 +: 8] = d_a[i*8 +: 8];
      else if (wr_b && same_addr && be_b[i])
        new_a[i*8 +: 8] = d_b[i*8 +: 8];

      if (wr_a && same_addr && be_a[i])
        new_b[i*8 +: 8] = d_a[i*8 +: 8];
      else if (wr_b && be_b[i])
        new_b[i*8 +: 8] = d_b[i*8 +: 8];
    end
  end

  assign rdata_a = (RDW_MODE == RDW_WRITE_FIRST) ? new_a : old_a;
  assign rdata_b = (RDW_MODE == RDW_WRITE_FIRST) ? new_b : old_b;

  // Storage is deliberately not reset so contents survive when no clear runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr_a) mem[addr_a] <= new_a;
      if (wr_b) mem[addr_b] <= new_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    collision_d = wr_a & wr_b & same_addr;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: init_done_d = 1'b1;
      default:  state_d     = ST_READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      collision_q <= collision_d;
    end
  end

  assign init_done = init_done_q;
  assign collision = collision_q;

  dpram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (acc_a),
    .in_data (rdata_a),
    .q       (q_a),
    .qv      (qv_a)
  );

  dpram_port_pipe #(.DATA_W(DATA_W), .OUT_REG(OUT_REG)) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (acc_b),
    .in_data (rdata_b),
    .q       (q_b),
    .qv      (qv_b)
  );

endmodule

`default_nettype wire

// File: tb/tb_dpram_be_clr.sv
// ============================================================================
// tb_dpram_be_clr : directed bench for dpram_be_clr (default build plus a
//                   write-first / no-clear / latency-1 build)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dpram_be_clr;

  localparam int DW = 256;
  localparam int BW = 32;
  localparam int AW = 5;

  localparam logic [BW-1:0] ALL  = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Default build: OUT_REG=1, read-first, clear on reset
  logic          rst_n, init_done, collision;
  logic          en_a, wen_a, en_b, wen_b, qv_a, qv_b;
  logic [BW-1:0] be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] d_a, d_b, q_a, q_b;

  // Second build: OUT_REG=0, write-first, no clear
  logic          rst2_n, init_done2, collision2;
  logic          en_a2, wen_a2, en_b2, wen_b2, qv_a2, qv_b2;
  logic [BW-1:0] be_a2, be_b2;
  logic [AW-1:0] addr_a2, addr_b2;
  logic [DW-1:0] d_a2, d_b2, q_a2, q_b2;

  dpram_be_clr u_dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .en_a(en_a), .wen_a(wen_a), .be_a(be_a), .addr_a(addr_a), .d_a(d_a),
    .q_a(q_a), .qv_a(qv_a),
    .en_b(en_b), .wen_b(wen_b), .be_b(be_b), .addr_b(addr_b), .d_b(d_b),
    .q_b(q_b), .qv_b(qv_b),
    .collision(collision)
  );

  dpram_be_clr #(.OUT_REG(0), .RDW_MODE(1), .CLR_ON_RST(0)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .init_done(init_done2),
    .en_a(en_a2), .wen_a(wen_a2), .be_a(be_a2), .addr_a(addr_a2), .d_a(d_a2),
    .q_a(q_a2), .qv_a(qv_a2),
    .en_b(en_b2), .wen_b(wen_b2), .be_b(be_b2), .addr_b(addr_b2), .d_b(d_b2),
    .q_b(q_b2), .qv_b(qv_b2),
    .collision(collision2)
  );

  typedef struct {
    logic          en_a, wen_a;
    logic [BW-1:0] be_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] d_a;
    logic          en_b, wen_b;
    logic [BW-1:0] be_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] d_b;
    logic          x_qv_a;
    logic [DW-1:0] x_q_a;
    logic          x_qv_b;
    logic [DW-1:0] x_q_b;
    logic          x_col;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(
    input logic ea, wa, input logic [BW-1:0] ba, input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic eb, wb, input logic [BW-1:0] bb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
    input logic xva, input logic [DW-1:0] xqa, input logic xvb, input logic [DW-1:0] xqb,
    input logic xc);
    vec_t v;
    v.en_a = ea; v.wen_a = wa; v.be_a = ba; v.addr_a = aa; v.d_a = da;
    v.en_b = eb; v.wen_b = wb; v.be_b = bb; v.addr_b = ab; v.d_b = db;
    v.x_qv_a = xva; v.x_q_a = xqa; v.x_qv_b = xvb; v.x_q_b = xqb; v.x_col = xc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle1();
    en_a = 0; wen_a = 0; be_a = '0; addr_a = '0; d_a = '0;
    en_b = 0; wen_b = 0; be_b = '0; addr_b = '0; d_b = '0;
  endtask

  task automatic idle2();
    en_a2 = 0; wen_a2 = 0; be_a2 = '0; addr_a2 = '0; d_a2 = '0;
    en_b2 = 0; wen_b2 = 0; be_b2 = '0; addr_b2 = '0; d_b2 = '0;
  endtask

  task automatic drive1(input vec_t v);
    en_a = v.en_a; wen_a = v.wen_a; be_a = v.be_a; addr_a = v.addr_a; d_a = v.d_a;
    en_b = v.en_b; wen_b = v.wen_b; be_b = v.be_b; addr_b = v.addr_b; d_b = v.d_b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_done rises, bounded; returns 0 if it never does.
  task automatic wait_init1(output int edge_n, output int qv_seen);
    edge_n  = 0;
    qv_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (qv_a) qv_seen++;
      if (init_done) begin
        edge_n = k;
        en_a   = 0;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, qs, nv, nz;

    vecs[0]  = mk(1,1,ALL,  1,256'd1337,     1,1,ALL,  3,256'd2022,     1,'0,1,'0,0);
    vecs[1]  = mk(1,0,'0,   3,'0,            1,0,'0,   1,'0,            1,256'd2022,1,256'd1337,0);
    vecs[2]  = mk(1,1,ALL,  2,ONES,          0,0,'0,   0,'0,            1,'0,0,256'd1337,0);
    vecs[3]  = mk(1,1,32'h3,2,256'h12345678, 0,0,'0,   0,'0,            1,ONES,0,256'd1337,0);
    vecs[4]  = mk(0,0,'0,   0,'0,            1,0,'0,   2,'0,            0,ONES,1,(~256'hFFFF) | 256'h5678,0);
    vecs[5]  = mk(1,1,32'h3,4,256'hAAAA,     1,1,32'h7,4,256'hBBBBBB,   1,'0,1,'0,1);
    vecs[6]  = mk(1,0,'0,   4,'0,            1,0,'0,   4,'0,            1,256'hBBAAAA,1,256'hBBAAAA,0);
    vecs[7]  = mk(1,1,ALL,  5,256'd10,       0,0,'0,   0,'0,            1,'0,0,256'hBBAAAA,0);
    vecs[8]  = mk(1,1,ALL,  5,256'd20,       1,0,'0,   5,'0,            1,256'd10,1,256'd10,0);
    vecs[9]  = mk(1,0,'0,   5,'0,            1,0,'0,   5,'0,            1,256'd20,1,256'd20,0);
    vecs[10] = mk(1,1,ALL,  6,256'd55,       0,0,'0,   0,'0,            1,'0,0,256'd20,0);
    vecs[11] = mk(1,1,'0,   6,256'd99,       0,0,'0,   0,'0,            1,256'd55,0,256'd20,0);
    vecs[12] = mk(1,0,'0,   6,'0,            1,0,'0,   1,'0,            1,256'd55,1,256'd1337,0);

    rst_n = 0; rst2_n = 0;
    idle1(); idle2();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", DW'(init_done), '0);
    chk("rst_qv_a", DW'(qv_a), '0);
    chk("rst_qv_b", DW'(qv_b), '0);
    chk("rst_q_a", q_a, '0);
    chk("rst_collision", DW'(collision), '0);

    // Clear sequence with a read held on port A throughout
    @(negedge clk);
    rst_n = 1;
    en_a = 1; wen_a = 0; addr_a = 5'd7;
    wait_init1(e, qs);
    chk("init_done_edge", DW'(e), DW'(32));
    chk("qv_during_clear", DW'(qs), '0);

    // Back-to-back sweep of every address, expecting zeros
    nv = 0; nz = 0;
    for (int i = 0; i < 34; i++) begin
      en_a = (i < 32);
      addr_a = AW'(i);
      tick();
      if (qv_a) begin
        nv++;
        if (q_a !== '0) nz++;
      end
    end
    idle1();
    chk("sweep_qv_count", DW'(nv), DW'(32));
    chk("sweep_nonzero", DW'(nz), '0);

    for (int i = 0; i < 13; i++) begin
      drive1(vecs[i]);
      tick();
      idle1();
      chk($sformatf("vec%0d_collision", i), DW'(collision), DW'(vecs[i].x_col));
      chk($sformatf("vec%0d_qv_a_early", i), DW'(qv_a), '0);
      chk($sformatf("vec%0d_qv_b_early", i), DW'(qv_b), '0);
      tick();
      chk($sformatf("vec%0d_qv_a", i), DW'(qv_a), DW'(vecs[i].x_qv_a));
      chk($sformatf("vec%0d_q_a", i), q_a, vecs[i].x_q_a);
      chk($sformatf("vec%0d_qv_b", i), DW'(qv_b), DW'(vecs[i].x_qv_b));
      chk($sformatf("vec%0d_q_b", i), q_b, vecs[i].x_q_b);
      chk($sformatf("vec%0d_collision_off", i), DW'(collision), '0);
    end

    // Reset while a latency-2 read is in flight; memory must be re-cleared
    en_a = 1; wen_a = 0; addr_a = 5'd1;
    tick();
    en_a = 0;
    rst_n = 0;
    #1;
    chk("midrst_qv_a", DW'(qv_a), '0);
    chk("midrst_q_a", q_a, '0);
    tick();
    chk("midrst_qv_a_after_edge", DW'(qv_a), '0);
    @(negedge clk);
    rst_n = 1;
    wait_init1(e, qs);
    chk("reclear_init_edge", DW'(e), DW'(32));
    en_a = 1; addr_a = 5'd1;
    tick();
    en_a = 0;
    tick();
    chk("reclear_qv_a", DW'(qv_a), 1);
    chk("reclear_q_a", q_a, '0);

    // Second build: write-first, latency 1, no clear
    chk("d2_rst_init_done", DW'(init_done2), '0);
    @(negedge clk);
    rst2_n = 1;
    tick();
    chk("d2_init_edge1", DW'(init_done2), 1);

    en_a2 = 1; wen_a2 = 1; be_a2 = ALL; addr_a2 = 5'd5; d_a2 = 256'd10;
    tick();
    idle2();
    chk("d2_wr_qv_a", DW'(qv_a2), 1);
    chk("d2_wr_q_a_merged", q_a2, 256'd10);

    en_a2 = 1; wen_a2 = 1; be_a2 = ALL; addr_a2 = 5'd5; d_a2 = 256'd20;
    en_b2 = 1; wen_b2 = 0; addr_b2 = 5'd5;
    tick();
    idle2();
    chk("d2_rdw_qv_b", DW'(qv_b2), 1);
    chk("d2_rdw_q_b", q_b2, 256'd20);
    chk("d2_rdw_q_a", q_a2, 256'd20);
    tick();
    chk("d2_qv_a_pulse_end", DW'(qv_a2), '0);

    en_a2 = 1; wen_a2 = 1; be_a2 = ALL; addr_a2 = 5'd9; d_a2 = '0;
    tick();
    en_a2 = 1; wen_a2 = 1; be_a2 = 32'h3; addr_a2 = 5'd9; d_a2 = 256'hAAAA;
    en_b2 = 1; wen_b2 = 1; be_b2 = 32'h7; addr_b2 = 5'd9; d_b2 = 256'hBBBBBB;
    tick();
    idle2();
    chk("d2_col", DW'(collision2), 1);
    chk("d2_col_q_a", q_a2, 256'hBBAAAA);
    chk("d2_col_q_b", q_b2, 256'hBBAAAA);
    tick();
    chk("d2_col_off", DW'(collision2), '0);

    // Reset before a latency-1 read completes; contents must survive
    en_a2 = 1; wen_a2 = 0; addr_a2 = 5'd5;
    @(negedge clk);
    rst2_n = 0;
    #1;
    chk("d2_midrst_q_a", q_a2, '0);
    tick();
    chk("d2_midrst_qv_a", DW'(qv_a2), '0);
    idle2();
    @(negedge clk);
    rst2_n = 1;
    tick();
    chk("d2_reinit", DW'(init_done2), 1);
    en_a2 = 1; wen_a2 = 0; addr_a2 = 5'd5;
    tick();
    idle2();
    chk("d2_retained_qv_a", DW'(qv_a2), 1);
    chk("d2_retained_q_a", q_a2, 256'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dpram_be_clr.md
Name: dpram_be_clr

Overview:
- Parametrised true dual-port RAM for the matrix engine's row/tile buffers.
- Successor to the fixed 256-bit x 32-entry dual-port RAM, generalised in:
  - data width and depth
  - per-byte write enables
  - selectable read latency
  - selectable read-during-write mode
- Adds a post-reset hardware clear sequence and cross-port write-collision detection, so tile buffers start at zero without host writes.

Parameters:
- DATA_W, 256: data width in bits; must be a multiple of 8. BE_W = DATA_W/8 is a derived localparam.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- OUT_REG, 1: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- RDW_MODE, 0: 0 = read-first (returns old data); 1 = write-first (returns new, merged data).
- CLR_ON_RST, 1: 1 zeroes every entry after reset; 0 skips the clear.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high once the clear sequence finishes; ports are serviced only while high.
- en_a  in  1  port A access request.
- wen_a  in  1  port A write (1) or read (0); qualified by en_a.
- be_a  in  DATA_W/8  port A byte enables for writes.
- addr_a  in  ADDR_W  port A address.
- d_a  in  DATA_W  port A write data.
- q_a  out  DATA_W  port A read data.
- qv_a  out  1  port A read-data valid pulse.
- en_b, wen_b, be_b, addr_b, d_b, q_b, qv_b: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset, asynchronous:
  - q_a, q_b, qv_a, qv_b, collision and init_done all go to 0.
  - Pipeline valids are cleared and the clear counter goes to 0.
  - FSM goes to ST_CLEAR if CLR_ON_RST=1, else ST_READY (init_done=1 on the first edge after release).
- ST_CLEAR:
  - One zero write per edge at the counter address, counter 0..DEPTH-1.
  - Port requests are ignored (no write, qv stays 0).
  - At the edge that clears DEPTH-1, go to ST_READY and set init_done=1. With defaults, init_done rises at edge 32 after rst_n release.
- ST_READY:
  - Each port accepts one access per cycle when en_x=1.
  - Write: only bytes with be_x[i]=1 are updated; wen_x=1 with be_x=0 leaves the entry unchanged.
  - Every accepted access (read or write) produces qv_x=1 exactly L = 1+OUT_REG cycles later, with q_x valid in the same cycle.
  - A write returns the pre-write entry when RDW_MODE=0, or the merged post-write entry when RDW_MODE=1.
  - q_x holds its last value when qv_x=0.
- Same-address events in one cycle, port A and port B:
  - Both write: A wins on bytes both enable; bytes enabled only by B take B's data; collision=1 one cycle later for one cycle.
  - One port reads while the other writes: the reader gets old data when RDW_MODE=0, merged new data when RDW_MODE=1.
  - Both read: both return identical data, no collision.
- Different addresses on the two ports: fully independent, no stall.
- Back-to-back accesses: fully pipelined, throughput of 1 per cycle per port.
- Reset mid-operation: in-flight reads are dropped (no qv). Memory is re-cleared if CLR_ON_RST=1, otherwise retained.
- Address wrap: none; addresses are exactly ADDR_W bits.

Decomposition:
- Package dpram_pkg holds:
  - typedef enum logic {ST_CLEAR, ST_READY} dpram_state_t;
  - localparams RDW_READ_FIRST=0, RDW_WRITE_FIRST=1.
- Sub-module dpram_port_pipe, instantiated once per port:
  - optional output register and valid pipeline, parametrised by DATA_W and OUT_REG.
- Storage array, byte-merge logic, collision logic and clear FSM live in the top module.

Test Plan:
- Clear sequence, defaults: release rst_n, then hold en_a=1 reading addr 7 during the clear.
  - Required: init_done rises at edge 32 and no qv_a appears before it.
  - Then read all 32 addresses: every q_a = 0.
- Dual write/read, OUT_REG=1:
  - Write A addr1 = 1337 and B addr3 = 2022, be all ones.
  - Then read A addr3 and B addr1: q_a = 2022 and q_b = 1337, with qv pulses exactly 2 cycles after the read cycle.
- Byte enables:
  - Write addr2 = 0x..FFFF_FFFF, then write 0x..1234_5678 with be=0x...0003.
  - Read returns 0x..FFFF_5678.
- Write collision: A writes addr4 = 0xAAAA with be=0x3 while B writes addr4 = 0xBBBBBB with be=0x7, same cycle.
  - Required: collision=1 for exactly one cycle, next edge.
  - Then read addr4 = 0xBBAAAA.
- Read-during-write, addr5 preloaded with 10:
  - A writes 20 while B reads addr5.
  - RDW_MODE=0 gives q_b = 10; RDW_MODE=1 gives q_b = 20; a later read gives 20 in both cases.
- Reset mid-read, CLR_ON_RST=0: issue a read on A, then assert rst_n low before qv_a.
  - Required: no qv_a, q_a=0, and previously written data is still readable after release.
